memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. It consumes the ALU result as a
//  load/store address or as pass-through data, and runs a req/ack handshake to data memory.
//  While an access is in flight it stalls upstream. It registers write-back data, destination
//  register and regWrite for the write-back stage.
// PARAMETERS
//  DATA_WIDTH  32   width of ALU result, store data and load data
//  REG_ADDR    5    width of destination register index
//  TIMEOUT     255  max cycles to wait for memAck before aborting (8-bit counter, 1..255)
// PORTS
//  clock             in   1           rising-edge clock
//  reset             in   1           asynchronous, active-low reset
//  validIn           in   1           execute stage presents a valid instruction this cycle
//  ALUResult         in   DATA_WIDTH  address (load/store) or result (ALU op)
//  writeData         in   DATA_WIDTH  store data (register read data two)
//  memRead           in   1           instruction is a load
//  memWrite          in   1           instruction is a store
//  memToReg          in   1           write-back selects load data instead of ALUResult
//  regWrite          in   1           instruction writes the register file
//  writeRegister     in   REG_ADDR    destination register index
//  stall             out  1           upstream must hold its outputs this cycle
//  memReq            out  1           data-memory request
//  memWe             out  1           1 = write, 0 = read (qualified by memReq)
//  memAddr           out  DATA_WIDTH  latched address
//  memWdata          out  DATA_WIDTH  latched store data
//  memAck            in   1           memory completes the request (1-cycle pulse)
//  memRdata          in   DATA_WIDTH  load data, valid in the memAck cycle
//  validOut          out  1           write-back outputs are valid (1-cycle pulse per instr)
//  writeBackData     out  DATA_WIDTH  data to the register file
//  regWriteOut       out  1           register-file write enable (0 on any fault)
//  writeRegisterOut  out  REG_ADDR    destination register index
//  misaligned        out  1           1-cycle pulse: memory op with ALUResult[1:0] != 0
//  memTimeout        out  1           1-cycle pulse: access aborted after TIMEOUT cycles
// BEHAVIOUR
//  - Reset: all outputs are 0, FSM is IDLE, counter is 0. Reset asserted mid-access drops
//    memReq immediately; the in-flight instruction is discarded.
//  - memOp = memRead | memWrite. If both are set, memWrite wins: store, no load data.
//  - stall is combinational: (state==ACCESS) | (state==IDLE & validIn & memOp & aligned).
//    It never asserts for ALU ops or misaligned ops.
//  - FSM IDLE:
//      - validIn & !memOp: next cycle validOut=1, writeBackData=ALUResult,
//        regWriteOut=regWrite. memToReg is ignored. Latency is 1.
//      - validIn & memOp & ALUResult[1:0]!=0: no request. Next cycle validOut=1,
//        regWriteOut=0, misaligned=1.
//      - validIn & memOp & aligned: latch addr, data, ctl and rd; go to ACCESS. memReq=1
//        from the next cycle; memWe=memWrite.
//      - memAck in IDLE is ignored.
//  - FSM ACCESS: memReq, memWe, memAddr and memWdata are held stable and the counter
//    increments each cycle.
//      - On memAck: memReq=0 next cycle, go to IDLE. Next cycle validOut=1,
//        writeBackData = (load & memToReg) ? memRdata (captured in the ack cycle) : address.
//        regWriteOut = latched regWrite.
//      - If the counter reaches TIMEOUT without memAck: memReq=0, go to IDLE. Next cycle
//        validOut=1, regWriteOut=0, memTimeout=1.
//      - memAck in the same cycle the counter reaches TIMEOUT counts as success.
//  - The counter clears on entry to ACCESS. Load latency = cycles to ack + 1.
//  - Outputs are registered. validOut, misaligned and memTimeout are single-cycle pulses.
//    writeBackData, writeRegisterOut and regWriteOut hold until the next validOut.
//  - A new instruction accepted in the IDLE cycle right after completion is back-to-back.
//    There is no bubble.
// TESTING
//  - ALU op ALUResult=0x1234, rd=5, regWrite=1 -> next cycle validOut=1,
//    writeBackData=0x1234, stall=0.
//  - Load addr=0x40, memAck 3 cycles after memReq with memRdata=0xDEADBEEF -> stall held
//    throughout; writeBackData=0xDEADBEEF, regWriteOut=1.
//  - Store addr=0x80, writeData=0xA5A5A5A5 -> memWe=1, memAddr=0x80,
//    memWdata=0xA5A5A5A5 stable until ack.
//  - Load addr=0x42 -> no memReq; next cycle misaligned=1, validOut=1, regWriteOut=0.
//  - No memAck, TIMEOUT=4 -> memReq drops after 4 cycles; memTimeout=1, regWriteOut=0.
//  - reset low 2 cycles into an access -> memReq=0 at once; after release, an ALU op
//    completes normally.

Source files
------------

// File: rtl/memory_access_stage_if.sv
// Bundles the execute-side inputs, the data-memory req/ack bus and the write-back outputs
// of the memory access stage.
interface memory_access_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5
);
  logic                  validIn;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  memRead;
  logic                  memWrite;
  logic                  memToReg;
  logic                  regWrite;
  logic [REG_ADDR-1:0]   writeRegister;
  logic                  stall;
  logic                  memReq;
  logic                  memWe;
  logic [DATA_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic                  memAck;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  validOut;
  logic [DATA_WIDTH-1:0] writeBackData;
  logic                  regWriteOut;
  logic [REG_ADDR-1:0]   writeRegisterOut;
  logic                  misaligned;
  logic                  memTimeout;

  // master: the surroundings (execute stage, data memory, write-back consumer)
  modport master (
    output validIn, ALUResult, writeData, memRead, memWrite, memToReg, regWrite,
           writeRegister, memAck, memRdata,
    input  stall, memReq, memWe, memAddr, memWdata, validOut, writeBackData,
           regWriteOut, writeRegisterOut, misaligned, memTimeout
  );

  // slave: the memory access stage itself
  modport slave (
    input  validIn, ALUResult, writeData, memRead, memWrite, memToReg, regWrite,
           writeRegister, memAck, memRdata,
    output stall, memReq, memWe, memAddr, memWdata, validOut, writeBackData,
           regWriteOut, writeRegisterOut, misaligned, memTimeout
  );
endinterface

// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: passes ALU results through, or runs one req/ack data-memory
// access at a time with alignment check and a bounded wait, stalling upstream meanwhile.
module memory_access_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR   = 5,
  parameter int TIMEOUT    = 255
) (
  input logic                  clock,
  input logic                  reset,
  memory_access_stage_if.slave bus
);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t                state_reg;
  logic [7:0]            cnt_reg;
  logic                  req_reg;
  logic                  we_reg;
  logic                  load_sel_reg;
  logic                  regwrite_lat_reg;
  logic [DATA_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [REG_ADDR-1:0]   rd_lat_reg;
  logic                  valid_out_reg;
  logic [DATA_WIDTH-1:0] wb_data_reg;
  logic                  regwrite_out_reg;
  logic [REG_ADDR-1:0]   rd_out_reg;
  logic                  misaligned_reg;
  logic                  timeout_reg;

  logic                  mem_op;
  logic                  aligned;
  logic                  accept;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] ack_data;

  assign mem_op      = bus.memRead | bus.memWrite;
  assign aligned     = (bus.ALUResult[1:0] == 2'b00);
  assign accept      = (state_reg == IDLE) & bus.validIn & mem_op & aligned;
  assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

  assign bus.stall = (state_reg == ACCESS) | accept;

  // Load data is taken straight from the bus in the ack cycle; stores and non-memToReg
  // loads write back the access address instead.
  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ack_sel
      assign ack_data[gi] = load_sel_reg ? bus.memRdata[gi] : addr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= 8'd0;
      req_reg          <= 1'b0;
      we_reg           <= 1'b0;
      load_sel_reg     <= 1'b0;
      regwrite_lat_reg <= 1'b0;
      addr_reg         <= '0;
      wdata_reg        <= '0;
      rd_lat_reg       <= '0;
      valid_out_reg    <= 1'b0;
      wb_data_reg      <= '0;
      regwrite_out_reg <= 1'b0;
      rd_out_reg       <= '0;
      misaligned_reg   <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      valid_out_reg  <= 1'b0;
      misaligned_reg <= 1'b0;
      timeout_reg    <= 1'b0;
      if (state_reg == IDLE) begin
        if (bus.validIn && !mem_op) begin
          valid_out_reg    <= 1'b1;
          wb_data_reg      <= bus.ALUResult;
          regwrite_out_reg <= bus.regWrite;
          rd_out_reg       <= bus.writeRegister;
        end else if (bus.validIn && !aligned) begin
          valid_out_reg    <= 1'b1;
          wb_data_reg      <= bus.ALUResult;
          regwrite_out_reg <= 1'b0;
          rd_out_reg       <= bus.writeRegister;
          misaligned_reg   <= 1'b1;
        end else if (accept) begin
          state_reg        <= ACCESS;
          cnt_reg          <= 8'd0;
          req_reg          <= 1'b1;
          we_reg           <= bus.memWrite;
          load_sel_reg     <= bus.memRead & ~bus.memWrite & bus.memToReg;
          regwrite_lat_reg <= bus.regWrite;
          addr_reg         <= bus.ALUResult;
          wdata_reg        <= bus.writeData;
          rd_lat_reg       <= bus.writeRegister;
        end
      end else begin
        cnt_reg <= cnt_reg + 8'd1;
        // An ack arriving in the last allowed cycle still wins over the timeout.
        if (bus.memAck) begin
          state_reg        <= IDLE;
          req_reg          <= 1'b0;
          valid_out_reg    <= 1'b1;
          wb_data_reg      <= ack_data;
          regwrite_out_reg <= regwrite_lat_reg;
          rd_out_reg       <= rd_lat_reg;
        end else if (timeout_hit) begin
          state_reg        <= IDLE;
          req_reg          <= 1'b0;
          valid_out_reg    <= 1'b1;
          wb_data_reg      <= addr_reg;
          regwrite_out_reg <= 1'b0;
          rd_out_reg       <= rd_lat_reg;
          timeout_reg      <= 1'b1;
        end
      end
    end
  end

  assign bus.memReq           = req_reg;
  assign bus.memWe            = we_reg;
  assign bus.memAddr          = addr_reg;
  assign bus.memWdata         = wdata_reg;
  assign bus.validOut         = valid_out_reg;
  assign bus.writeBackData    = wb_data_reg;
  assign bus.regWriteOut      = regwrite_out_reg;
  assign bus.writeRegisterOut = rd_out_reg;
  assign bus.misaligned       = misaligned_reg;
  assign bus.memTimeout       = timeout_reg;
endmodule

// File: tb/tb_memory_access_stage.sv
// Scenario bench for memory_access_stage: expected write-back records are queued when an
// instruction is issued and popped when validOut fires.
module tb_memory_access_stage;
  localparam logic [40:0] FULL_MASK  = '1;
  localparam logic [40:0] NO_WB_MASK = {1'b1, 32'h0, 8'hFF};

  typedef struct packed {
    logic [40:0] v;
    logic [40:0] m;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t e;
  logic [40:0] got;

  memory_access_stage_if #(.DATA_WIDTH(32), .REG_ADDR(5)) bus ();

  memory_access_stage #(.DATA_WIDTH(32), .REG_ADDR(5), .TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [40:0] obs();
    return {bus.validOut, bus.writeBackData, bus.regWriteOut, bus.writeRegisterOut,
            bus.misaligned, bus.memTimeout};
  endfunction

  function automatic logic [40:0] mk(input logic [31:0] wb, input logic rw,
                                      input logic [4:0] rd, input logic mis, input logic to);
    return {1'b1, wb, rw, rd, mis, to};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.validIn  = 1'b0;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.memToReg = 1'b0;
    bus.regWrite = 1'b0;
    bus.memAck   = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd_en,
                       input logic wr_en, input logic m2r, input logic rw, input logic [4:0] rd);
    bus.validIn       = 1'b1;
    bus.ALUResult     = a;
    bus.writeData     = wd;
    bus.memRead       = rd_en;
    bus.memWrite      = wr_en;
    bus.memToReg      = m2r;
    bus.regWrite      = rw;
    bus.writeRegister = rd;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    got = obs();
    if (got !== 41'h0 || bus.memReq !== 1'b0 || bus.stall !== 1'b0 || bus.memWe !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%h req=%b stall=%b we=%b, required all 0",
               got, bus.memReq, bus.stall, bus.memWe);
    end
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    issue(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
    bus.memAck = 1'b1;
    sb.push_back('{v: mk(32'h1234, 1'b1, 5'd5, 1'b0, 1'b0), m: FULL_MASK});
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_stall: got %b required 0", bus.stall);
    end
    tick();
    idle_inputs();
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v || bus.memReq !== 1'b0) begin
      errors++;
      $display("FAIL alu_result: got %h req=%b required %h req=0", got, bus.memReq, e.v);
    end
    $display("alu op: wb=%h rd=%0d", bus.writeBackData, bus.writeRegisterOut);
    tick();
    checks++;
    if (bus.validOut !== 1'b0) begin
      errors++;
      $display("FAIL alu_pulse: validOut got %b required 0", bus.validOut);
    end
  endtask

  task automatic test_load();
    issue(32'h40, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    sb.push_back('{v: mk(32'hDEADBEEF, 1'b1, 5'd7, 1'b0, 1'b0), m: FULL_MASK});
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL load_stall_accept: got %b required 1", bus.stall);
    end
    tick();
    bus.validIn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.memReq !== 1'b1 || bus.stall !== 1'b1 || bus.memWe !== 1'b0 ||
          bus.memAddr !== 32'h40 || bus.validOut !== 1'b0) begin
        errors++;
        $display("FAIL load_access_c%0d: req=%b stall=%b we=%b addr=%h vo=%b required 1 1 0 40 0",
                 k, bus.memReq, bus.stall, bus.memWe, bus.memAddr, bus.validOut);
      end
      if (k == 2) begin
        bus.memAck   = 1'b1;
        bus.memRdata = 32'hDEADBEEF;
      end
      tick();
    end
    bus.memAck   = 1'b0;
    bus.memRdata = 32'h0;
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v || bus.memReq !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL load_result: got %h req=%b stall=%b required %h req=0 stall=0",
               got, bus.memReq, bus.stall, e.v);
    end
    $display("load: addr=40 wb=%h rw=%b", bus.writeBackData, bus.regWriteOut);
  endtask

  task automatic test_store();
    issue(32'h80, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);
    sb.push_back('{v: mk(32'h80, 1'b0, 5'd9, 1'b0, 1'b0), m: FULL_MASK});
    tick();
    bus.validIn   = 1'b0;
    bus.ALUResult = 32'hFFFFFFFC;
    bus.writeData = 32'h0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.memReq !== 1'b1 || bus.memWe !== 1'b1 || bus.memAddr !== 32'h80 ||
          bus.memWdata !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL store_bus_c%0d: req=%b we=%b addr=%h wdata=%h required 1 1 80 a5a5a5a5",
                 k, bus.memReq, bus.memWe, bus.memAddr, bus.memWdata);
      end
      if (k == 1) begin
        bus.memAck   = 1'b1;
        bus.memRdata = 32'h12345678;
      end
      tick();
    end
    bus.memAck = 1'b0;
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v || bus.memReq !== 1'b0) begin
      errors++;
      $display("FAIL store_result: got %h req=%b required %h req=0", got, bus.memReq, e.v);
    end
    $display("store: addr=80 wb=%h rw=%b", bus.writeBackData, bus.regWriteOut);
  endtask

  task automatic test_misaligned();
    issue(32'h42, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    sb.push_back('{v: mk(32'h0, 1'b0, 5'd3, 1'b1, 1'b0), m: NO_WB_MASK});
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_stall: got %b required 0", bus.stall);
    end
    tick();
    idle_inputs();
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v || bus.memReq !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_result: got %h req=%b required %h req=0",
               got & e.m, bus.memReq, e.v);
    end
    $display("misaligned load: addr=42 mis=%b rw=%b", bus.misaligned, bus.regWriteOut);
    tick();
    checks++;
    if (bus.validOut !== 1'b0 || bus.misaligned !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_pulse: vo=%b mis=%b required 0 0", bus.validOut, bus.misaligned);
    end
  endtask

  task automatic test_timeout();
    int n;
    issue(32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    sb.push_back('{v: mk(32'h0, 1'b0, 5'd4, 1'b0, 1'b1), m: NO_WB_MASK});
    tick();
    idle_inputs();
    n = 0;
    while (bus.memReq === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL timeout_req_cycles: got %0d required 4", n);
    end
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v) begin
      errors++;
      $display("FAIL timeout_result: got %h required %h", got & e.m, e.v);
    end
    $display("timeout: req cycles=%0d to=%b rw=%b", n, bus.memTimeout, bus.regWriteOut);
    tick();
    checks++;
    if (bus.validOut !== 1'b0 || bus.memTimeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: vo=%b to=%b required 0 0", bus.validOut, bus.memTimeout);
    end
  endtask

  task automatic test_ack_boundary();
    issue(32'h104, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    sb.push_back('{v: mk(32'h0BADF00D, 1'b1, 5'd6, 1'b0, 1'b0), m: FULL_MASK});
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    bus.memAck   = 1'b1;
    bus.memRdata = 32'h0BADF00D;
    tick();
    bus.memAck = 1'b0;
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v) begin
      errors++;
      $display("FAIL ack_at_limit: got %h required %h", got, e.v);
    end
    $display("ack at limit: wb=%h to=%b", bus.writeBackData, bus.memTimeout);
  endtask

  task automatic test_back_to_back();
    issue(32'h200, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8);
    sb.push_back('{v: mk(32'h200, 1'b1, 5'd8, 1'b0, 1'b0), m: FULL_MASK});
    tick();
    idle_inputs();
    bus.memAck   = 1'b1;
    bus.memRdata = 32'hCAFEF00D;
    tick();
    bus.memAck = 1'b0;
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v) begin
      errors++;
      $display("FAIL b2b_first: got %h required %h", got, e.v);
    end
    $display("b2b load (no memToReg): wb=%h", bus.writeBackData);
    issue(32'h55AA, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd10);
    sb.push_back('{v: mk(32'h55AA, 1'b1, 5'd10, 1'b0, 1'b0), m: FULL_MASK});
    tick();
    idle_inputs();
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v) begin
      errors++;
      $display("FAIL b2b_second: got %h required %h", got, e.v);
    end
    $display("b2b alu: wb=%h", bus.writeBackData);
  endtask

  task automatic test_reset_mid_access();
    issue(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11);
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bus.memReq !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: memReq got %b required 1", bus.memReq);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.memReq !== 1'b0 || bus.stall !== 1'b0 || bus.validOut !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_drop: req=%b stall=%b vo=%b required 0 0 0",
               bus.memReq, bus.stall, bus.validOut);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.validOut !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_discard: validOut got %b required 0", bus.validOut);
    end
    issue(32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12);
    sb.push_back('{v: mk(32'h77, 1'b1, 5'd12, 1'b0, 1'b0), m: FULL_MASK});
    tick();
    idle_inputs();
    checks++;
    got = obs();
    e = sb.pop_front();
    if ((got & e.m) !== e.v) begin
      errors++;
      $display("FAIL rst_mid_after_alu: got %h required %h", got, e.v);
    end
    $display("after reset alu: wb=%h", bus.writeBackData);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    clock             = 1'b0;
    reset             = 1'b0;
    bus.ALUResult     = 32'h0;
    bus.writeData     = 32'h0;
    bus.writeRegister = 5'd0;
    bus.memRdata      = 32'h0;
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_ack_boundary();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
